// File: rtl/enemy_life_ctrl_pkg.sv
// Shared definitions for the enemy life-cycle controller: slot state encoding,
// per-class defaults and sizing helpers.
package enemy_life_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_UNVISUAL = 2'b00,
    ST_NORMAL   = 2'b01,
    ST_HIT      = 2'b10,
    ST_DOWN     = 2'b11
  } slot_state_t;

  typedef enum logic [1:0] {
    CLASS_SMALL  = 2'd0,
    CLASS_MEDIUM = 2'd1,
    CLASS_LARGE  = 2'd2
  } enemy_class_t;

  localparam int COLOR_GRAY_DEPTH = 4;
  localparam int FRAME_TICKS_DEF  = 4_000_000;
  localparam int HIT_TICKS_DEF    = 2_000_000;

  function automatic int class_hp(input enemy_class_t cls);
    case (cls)
      CLASS_SMALL:  return 1;
      CLASS_MEDIUM: return 3;
      CLASS_LARGE:  return 8;
      default:      return 1;
    endcase
  endfunction

  function automatic int class_down_frames(input enemy_class_t cls);
    case (cls)
      CLASS_SMALL:  return 3;
      CLASS_MEDIUM: return 4;
      CLASS_LARGE:  return 6;
      default:      return 3;
    endcase
  endfunction

  // Counter width for n distinct values, never narrower than one bit.
  function automatic int width_of(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/enemy_slot_fsm.sv
// Life cycle of one enemy slot: spawn, hit flash with hit points, and a timed
// multi-frame explosion before the slot becomes free again.
module enemy_slot_fsm
  import enemy_life_ctrl_pkg::*;
#(
  parameter int HP          = 1,
  parameter int DOWN_FRAMES = 3,
  parameter int FRAME_TICKS = FRAME_TICKS_DEF,
  parameter int HIT_TICKS   = HIT_TICKS_DEF,
  parameter int FRAME_W     = width_of(DOWN_FRAMES)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               spawn,
  input  logic               addressed,
  input  logic               crash_bullet,
  input  logic               crash_me,
  input  logic               bomb,
  output slot_state_t        state,
  output logic [FRAME_W-1:0] frame,
  output logic               enter_down
);

  localparam int HP_W   = $clog2(HP + 1);
  localparam int TICK_W = width_of((FRAME_TICKS > HIT_TICKS) ? FRAME_TICKS : HIT_TICKS);

  localparam logic [HP_W-1:0]    HP_INIT         = HP_W'(HP);
  localparam logic [HP_W-1:0]    HP_LAST         = HP_W'(1);
  localparam logic [TICK_W-1:0]  HIT_LAST        = TICK_W'(HIT_TICKS - 1);
  localparam logic [TICK_W-1:0]  FRAME_TICK_LAST = TICK_W'(FRAME_TICKS - 1);
  localparam logic [FRAME_W-1:0] FRAME_LAST      = FRAME_W'(DOWN_FRAMES - 1);

  slot_state_t        state_r;
  logic [HP_W-1:0]    hp_r;
  logic [FRAME_W-1:0] frame_r;
  logic [TICK_W-1:0]  tick_r;
  logic               live_s;
  logic               kill_s;
  logic               wound_s;

  // Kill/wound decisions; a bomb or a body collision outranks a bullet.
  always_comb begin
    live_s     = (state_r == ST_NORMAL) || (state_r == ST_HIT);
    kill_s     = bomb || (addressed && (crash_me || (crash_bullet && (hp_r == HP_LAST))));
    wound_s    = addressed && crash_bullet && (hp_r != HP_LAST);
    enter_down = en && live_s && kill_s;
  end

  // Slot state, hit points, explosion frame and shared frame/flash timer.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_UNVISUAL;
      hp_r    <= HP_INIT;
      frame_r <= '0;
      tick_r  <= '0;
    end else if (en) begin
      case (state_r)
        ST_UNVISUAL: begin
          if (spawn) begin
            state_r <= ST_NORMAL;
            hp_r    <= HP_INIT;
            tick_r  <= '0;
          end
        end
        ST_NORMAL, ST_HIT: begin
          if (kill_s) begin
            state_r <= ST_DOWN;
            frame_r <= '0;
            tick_r  <= '0;
          end else if (wound_s) begin
            state_r <= ST_HIT;
            hp_r    <= hp_r - HP_W'(1);
            tick_r  <= '0;
          end else if (state_r == ST_HIT) begin
            if (tick_r == HIT_LAST) begin
              state_r <= ST_NORMAL;
              tick_r  <= '0;
            end else begin
              tick_r <= tick_r + TICK_W'(1);
            end
          end
        end
        ST_DOWN: begin
          if (tick_r == FRAME_TICK_LAST) begin
            tick_r <= '0;
            if (frame_r == FRAME_LAST) begin
              state_r <= ST_UNVISUAL;
              frame_r <= '0;
            end else begin
              frame_r <= frame_r + FRAME_W'(1);
            end
          end else begin
            tick_r <= tick_r + TICK_W'(1);
          end
        end
        default: begin
          state_r <= ST_UNVISUAL;
          frame_r <= '0;
          tick_r  <= '0;
        end
      endcase
    end
  end

  assign state = state_r;
  assign frame = frame_r;

endmodule

// File: rtl/enemy_life_ctrl.sv
// Enemy pool controller: one life-cycle FSM per slot, the sprite-frame pixel
// mux for the slot under the current pixel, and the per-event kill counter.
module enemy_life_ctrl
  import enemy_life_ctrl_pkg::*;
#(
  parameter int NUM         = 8,
  parameter int IDX_W       = 3,
  parameter int HP          = class_hp(CLASS_SMALL),
  parameter int DOWN_FRAMES = class_down_frames(CLASS_SMALL),
  parameter int FRAME_TICKS = FRAME_TICKS_DEF,
  parameter int HIT_TICKS   = HIT_TICKS_DEF,
  parameter int GRAY_W      = COLOR_GRAY_DEPTH
) (
  input  logic                                  clk_vga,
  input  logic                                  rst,
  input  logic                                  en_i,
  input  logic                                  spawn_i,
  input  logic [IDX_W-1:0]                      spawn_idx_i,
  input  logic                                  enemy_vali_i,
  input  logic [IDX_W-1:0]                      curr_enemy_idx_i,
  input  logic                                  crash_bullet_i,
  input  logic                                  crash_me_i,
  input  logic                                  bomb_i,
  input  logic [(2+DOWN_FRAMES)*(1+GRAY_W)-1:0] bram_info_i,
  output logic [NUM-1:0]                        disappear_o,
  output logic                                  vga_alpha_o,
  output logic [3*GRAY_W-1:0]                   vga_rgb_o,
  output logic [IDX_W:0]                        kill_cnt_o
);

  localparam int W       = 1 + GRAY_W;
  localparam int NF      = 2 + DOWN_FRAMES;
  localparam int SEL_W   = width_of(NF);
  localparam int FRAME_W = width_of(DOWN_FRAMES);
  localparam int CNT_W   = IDX_W + 1;

  logic [1:0]         slot_state_s [NUM];
  logic [FRAME_W-1:0] slot_frame_s [NUM];
  logic [NUM-1:0]     spawn_sel_s;
  logic [NUM-1:0]     addressed_s;
  logic [NUM-1:0]     enter_down_s;
  logic [W-1:0]       frames_s [NF];
  logic [1:0]         sel_state_s;
  logic [FRAME_W-1:0] sel_frame_s;
  logic [SEL_W-1:0]   frame_idx_s;
  logic [W-1:0]       pix_s;
  logic               visible_s;
  logic [CNT_W-1:0]   kill_sum_s;
  logic [CNT_W-1:0]   kill_cnt_r;

  // Per-slot decode of spawn target and current-pixel owner.
  always_comb begin
    for (int s = 0; s < NUM; s++) begin
      spawn_sel_s[s] = spawn_i && (spawn_idx_i == IDX_W'(s));
      addressed_s[s] = enemy_vali_i && (curr_enemy_idx_i == IDX_W'(s));
    end
  end

  for (genvar g = 0; g < NUM; g++) begin : g_slot
    slot_state_t state_s;

    enemy_slot_fsm #(
      .HP          (HP),
      .DOWN_FRAMES (DOWN_FRAMES),
      .FRAME_TICKS (FRAME_TICKS),
      .HIT_TICKS   (HIT_TICKS),
      .FRAME_W     (FRAME_W)
    ) u_slot (
      .clk          (clk_vga),
      .rst          (rst),
      .en           (en_i),
      .spawn        (spawn_sel_s[g]),
      .addressed    (addressed_s[g]),
      .crash_bullet (crash_bullet_i),
      .crash_me     (crash_me_i),
      .bomb         (bomb_i),
      .state        (state_s),
      .frame        (slot_frame_s[g]),
      .enter_down   (enter_down_s[g])
    );

    assign slot_state_s[g] = state_s;
    assign disappear_o[g]  = (state_s == ST_UNVISUAL);
  end

  // Pixel mux; at most one slot is addressed, and none when the index is out of range.
  always_comb begin
    sel_state_s = 2'b00;
    sel_frame_s = '0;
    for (int s = 0; s < NUM; s++) begin
      sel_state_s = sel_state_s | (addressed_s[s] ? slot_state_s[s] : 2'b00);
      sel_frame_s = sel_frame_s | (addressed_s[s] ? slot_frame_s[s] : '0);
    end
    for (int k = 0; k < NF; k++) begin
      frames_s[k] = bram_info_i[(NF-1-k)*W +: W];
    end
    case (sel_state_s)
      ST_HIT:  frame_idx_s = SEL_W'(1);
      ST_DOWN: frame_idx_s = SEL_W'(2) + SEL_W'(sel_frame_s);
      default: frame_idx_s = SEL_W'(0);
    endcase
    pix_s       = frames_s[frame_idx_s];
    visible_s   = (sel_state_s != ST_UNVISUAL);
    vga_alpha_o = visible_s ? pix_s[W-1] : 1'b0;
    vga_rgb_o   = visible_s ? {3{pix_s[GRAY_W-1:0]}} : '0;
  end

  // Number of slots dying on this edge.
  always_comb begin
    kill_sum_s = '0;
    for (int s = 0; s < NUM; s++) begin
      kill_sum_s = kill_sum_s + CNT_W'(enter_down_s[s]);
    end
  end

  // One-cycle kill count pulse.
  always_ff @(posedge clk_vga) begin
    if (rst) begin
      kill_cnt_r <= '0;
    end else begin
      kill_cnt_r <= kill_sum_s;
    end
  end

  assign kill_cnt_o = kill_cnt_r;

endmodule

// File: tb/tb_enemy_life_ctrl.sv
// Directed and random stimulus for enemy_life_ctrl, checked every cycle against
// a remaining-cycles model of each slot's life cycle.
module tb_enemy_life_ctrl;

  localparam int NUM = 8;
  localparam int IDX_W = 3;
  localparam int HP = 3;
  localparam int DF = 3;
  localparam int FT = 6;
  localparam int HT = 4;
  localparam int GW = 4;
  localparam int W = 1 + GW;
  localparam int NF = 2 + DF;

  logic clk = 1'b0;
  logic rst, en, spawn, vali, bullet, me, bomb;
  logic [IDX_W-1:0] spawn_idx, cur_idx;
  logic [NF*W-1:0] bram;
  logic [NUM-1:0] disappear;
  logic alpha;
  logic [3*GW-1:0] rgb;
  logic [IDX_W:0] kill_cnt;

  int checks = 0;
  int errors = 0;
  bit pix_ok = 1'b0;

  int m_alive [NUM];
  int m_hp [NUM];
  int m_flash [NUM];
  int m_boom [NUM];
  int exp_kill = 0;

  enemy_life_ctrl #(
    .NUM(NUM), .IDX_W(IDX_W), .HP(HP), .DOWN_FRAMES(DF),
    .FRAME_TICKS(FT), .HIT_TICKS(HT), .GRAY_W(GW)
  ) dut (
    .clk_vga(clk), .rst(rst), .en_i(en), .spawn_i(spawn), .spawn_idx_i(spawn_idx),
    .enemy_vali_i(vali), .curr_enemy_idx_i(cur_idx), .crash_bullet_i(bullet),
    .crash_me_i(me), .bomb_i(bomb), .bram_info_i(bram), .disappear_o(disappear),
    .vga_alpha_o(alpha), .vga_rgb_o(rgb), .kill_cnt_o(kill_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int s = 0; s < NUM; s++) begin
      m_alive[s] = 0; m_hp[s] = HP; m_flash[s] = 0; m_boom[s] = 0;
    end
  endtask

  // Apply one clock edge to the model using the inputs present at that edge.
  task automatic model_edge();
    int kills;
    bit a;
    kills = 0;
    if (rst) begin
      model_reset();
    end else if (en) begin
      for (int s = 0; s < NUM; s++) begin
        a = vali && (cur_idx == IDX_W'(s));
        if (m_boom[s] > 0) begin
          m_boom[s]--;
        end else if (m_alive[s] != 0) begin
          if (bomb || (a && me) || (a && bullet && m_hp[s] == 1)) begin
            m_alive[s] = 0; m_boom[s] = DF * FT; m_flash[s] = 0; kills++;
          end else if (a && bullet) begin
            m_hp[s]--; m_flash[s] = HT;
          end else if (m_flash[s] > 0) begin
            m_flash[s]--;
          end
        end else if (spawn && spawn_idx == IDX_W'(s)) begin
          m_alive[s] = 1; m_hp[s] = HP; m_flash[s] = 0;
        end
      end
    end
    exp_kill = kills;
  endtask

  function automatic logic [NUM-1:0] model_disappear();
    logic [NUM-1:0] d;
    for (int s = 0; s < NUM; s++) d[s] = (m_alive[s] == 0) && (m_boom[s] == 0);
    return d;
  endfunction

  task automatic chk_pixel();
    logic exp_a;
    logic [3*GW-1:0] exp_rgb;
    logic [W-1:0] f;
    int k;
    exp_a = 1'b0;
    exp_rgb = '0;
    if (vali && (m_alive[cur_idx] != 0 || m_boom[cur_idx] > 0)) begin
      if (m_boom[cur_idx] > 0) k = 2 + (DF * FT - m_boom[cur_idx]) / FT;
      else if (m_flash[cur_idx] > 0) k = 1;
      else k = 0;
      f = W'(bram >> ((NF - 1 - k) * W));
      exp_a = f[W-1];
      exp_rgb = {3{f[GW-1:0]}};
    end
    chk("vga_alpha", 32'(alpha), 32'(exp_a));
    chk("vga_rgb", 32'(rgb), 32'(exp_rgb));
  endtask

  task automatic step();
    #1;
    if (pix_ok) chk_pixel();
    @(posedge clk);
    model_edge();
    #1;
    pix_ok = 1'b1;
    chk("disappear", 32'(disappear), 32'(model_disappear()));
    chk("kill_cnt", 32'(kill_cnt), 32'(exp_kill));
  endtask

  task automatic idle();
    rst = 1'b0; en = 1'b1; spawn = 1'b0; spawn_idx = '0; vali = 1'b0; cur_idx = '0;
    bullet = 1'b0; me = 1'b0; bomb = 1'b0; bram = (NF*W)'($urandom);
  endtask

  task automatic watch(input int idx);
    idle(); vali = 1'b1; cur_idx = IDX_W'(idx);
  endtask

  task automatic spawn_slot(input int idx);
    idle(); spawn = 1'b1; spawn_idx = IDX_W'(idx); step();
  endtask

  initial begin
    model_reset();
    idle();
    rst = 1'b1; vali = 1'b1; cur_idx = 3'd2;
    step(); step();
    chk("reset_disappear", 32'(disappear), 32'hFF);
    chk("reset_alpha", 32'(alpha), 32'h0);
    chk("reset_kill", 32'(kill_cnt), 32'h0);

    // Bullet wounds slot 2, flash times out, two more bullets kill it.
    spawn_slot(2);
    watch(2); bullet = 1'b1; step();
    for (int i = 0; i < HT + 2; i++) begin watch(2); step(); end
    watch(2); bullet = 1'b1; step();
    watch(2); bullet = 1'b1; step();
    chk("bullet_kill", 32'(kill_cnt), 32'h1);
    for (int i = 0; i < DF * FT - 1; i++) begin watch(2); step(); end
    chk("still_exploding", 32'(disappear[2]), 32'h0);
    watch(2); step();
    chk("explosion_done", 32'(disappear[2]), 32'h1);

    // Body collision together with a bullet on a full-health slot.
    spawn_slot(4);
    watch(4); me = 1'b1; bullet = 1'b1; step();
    chk("crash_me_kill", 32'(kill_cnt), 32'h1);

    // Bomb kills the live slots, ignores the exploding ones.
    spawn_slot(0); spawn_slot(1); spawn_slot(5); spawn_slot(3);
    watch(3); me = 1'b1; step();
    for (int i = 0; i < FT; i++) begin watch(3); step(); end
    watch(3); bomb = 1'b1; step();
    chk("bomb_kills", 32'(kill_cnt), 32'h3);
    for (int i = 0; i < DF * FT + 2; i++) begin watch(3); step(); end

    // Enable low freezes an explosion and drops spawn/collisions.
    spawn_slot(6);
    watch(6); me = 1'b1; step();
    for (int i = 0; i < 8; i++) begin watch(6); step(); end
    for (int i = 0; i < 100; i++) begin
      watch(6); en = 1'b0; spawn = 1'b1; spawn_idx = 3'd6; bullet = 1'b1; bomb = 1'b1; step();
    end
    chk("frozen_visible", 32'(disappear[6]), 32'h0);
    for (int i = 0; i < DF * FT - 8; i++) begin watch(6); step(); end
    chk("resume_done", 32'(disappear[6]), 32'h1);

    // Reset mid-explosion, with a spawn in the reset cycle.
    spawn_slot(1);
    watch(1); me = 1'b1; step();
    for (int i = 0; i < 5; i++) begin watch(1); step(); end
    idle(); rst = 1'b1; spawn = 1'b1; spawn_idx = 3'd1; step();
    chk("rst_mid_disappear", 32'(disappear[1]), 32'h1);
    chk("rst_mid_kill", 32'(kill_cnt), 32'h0);
    watch(1); step();
    chk("rst_spawn_lost", 32'(disappear[1]), 32'h1);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 299) == 0);
      en = ($urandom_range(0, 9) != 0);
      spawn = ($urandom_range(0, 2) == 0);
      spawn_idx = IDX_W'($urandom);
      vali = ($urandom_range(0, 1) == 0);
      cur_idx = IDX_W'($urandom);
      bullet = ($urandom_range(0, 3) == 0);
      me = ($urandom_range(0, 19) == 0);
      bomb = ($urandom_range(0, 149) == 0);
      bram = (NF*W)'($urandom);
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
